// File: rtl/parity_frame_tx_pkg.sv
// parity_frame_tx_pkg: shared state encodings and line levels for the parity frame transmitter
package parity_frame_tx_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
    localparam int   FRAME_BITS  = 7;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
endpackage

// File: rtl/parity_frame_tx_odd_parity4.sv
// odd_parity4: combinational odd parity bit over four inputs
module odd_parity4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic p
);
    assign p = ~(a ^ b ^ c ^ d);
endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: sends an accepted nibble as start, 4 data bits LSB first, odd parity, stop
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic       parity_out,
    output logic       frame_done
);
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         bit_idx, bit_idx_nxt;
    logic [3:0]         shift, shift_nxt;
    logic               tx_nxt, par_nxt, done_nxt, p, end_bit;
    odd_parity4 u_par (.a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]), .p(p));
    assign end_bit   = cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign din_ready = state == S_IDLE;
    assign busy      = state != S_IDLE;
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        par_nxt     = parity_out;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE:   if (din_valid) begin
                          state_nxt = S_START;
                          shift_nxt = din;
                          par_nxt   = p;
                      end
            S_START:  if (end_bit) begin
                          state_nxt   = S_DATA;
                          bit_idx_nxt = 2'd0;
                      end
            S_DATA:   if (end_bit) begin
                          shift_nxt   = shift >> 1;
                          bit_idx_nxt = bit_idx + 2'd1;
                          state_nxt   = bit_idx == 2'd3 ? S_PARITY : S_DATA;
                      end
            S_PARITY: if (end_bit) state_nxt = S_STOP;
            S_STOP:   if (end_bit) begin
                          state_nxt = S_IDLE;
                          done_nxt  = 1'b1;
                      end
            default:  state_nxt = S_IDLE;
        endcase
        cnt_nxt = (state == S_IDLE || end_bit) ? '0 : cnt + 1'b1;
        // tx is registered, so it is decoded from where the FSM is heading
        tx_nxt  = state_nxt == S_START  ? START_LEVEL :
                  state_nxt == S_DATA   ? shift_nxt[0] :
                  state_nxt == S_PARITY ? par_nxt :
                  state_nxt == S_STOP   ? STOP_LEVEL : IDLE_LEVEL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= 2'd0;
            shift      <= 4'd0;
            tx         <= IDLE_LEVEL;
            parity_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            tx         <= tx_nxt;
            parity_out <= par_nxt;
            frame_done <= done_nxt;
        end
    end
endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: directed checks of framing, timing, handshake and reset for three bit rates
module tb_parity_frame_tx;
    logic       clk, rst, din_valid;
    logic [3:0] din;
    logic       rdy4, tx4, busy4, par4, done4;
    logic       rdy2, tx2, busy2, par2, done2;
    logic       rdy1, tx1, busy1, par1, done1;
    logic       tx_m, busy_m, par_m, done_m, rdy_m;
    int         csel = 4;
    int         checks = 0;
    int         errors = 0;

    parity_frame_tx #(.CLKS_PER_BIT(4)) u4 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy4), .tx(tx4), .busy(busy4), .parity_out(par4), .frame_done(done4));
    parity_frame_tx #(.CLKS_PER_BIT(2)) u2 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy2), .tx(tx2), .busy(busy2), .parity_out(par2), .frame_done(done2));
    parity_frame_tx #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .tx(tx1), .busy(busy1), .parity_out(par1), .frame_done(done1));

    always_comb begin
        tx_m   = csel == 4 ? tx4   : csel == 2 ? tx2   : tx1;
        busy_m = csel == 4 ? busy4 : csel == 2 ? busy2 : busy1;
        par_m  = csel == 4 ? par4  : csel == 2 ? par2  : par1;
        done_m = csel == 4 ? done4 : csel == 2 ? done2 : done1;
        rdy_m  = csel == 4 ? rdy4  : csel == 2 ? rdy2  : rdy1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s C=%0d: observed %0h expected %0h", tag, csel, obs, exp);
        end
    endtask

    task automatic accept(input logic [3:0] d);
        din       = d;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; walks the whole frame and the cycle after it
    task automatic check_frame(input int c, input logic [3:0] d, input int inj);
        logic       p;
        logic [6:0] f;
        p = ~^d;
        f = {1'b1, p, d, 1'b0};
        check("parity_out", par_m, p);
        for (int j = 0; j < parity_frame_tx_pkg::FRAME_BITS * c; j++) begin
            if (j == inj) begin
                din       = 4'hF;
                din_valid = 1'b1;
            end
            if (inj >= 0 && j == inj + 1) din_valid = 1'b0;
            check($sformatf("tx[%0d]", j), tx_m, f[j / c]);
            check($sformatf("busy[%0d]", j), busy_m, 1);
            check($sformatf("frame_done[%0d]", j), done_m, 0);
            tick;
        end
        check("done_pulse", done_m, 1);
        check("ready_after", rdy_m, 1);
        check("busy_after", busy_m, 0);
        check("idle_tx", tx_m, 1);
    endtask

    initial begin
        rst       = 1'b0;
        din       = 4'h0;
        din_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_tx", tx4, 1);
        check("rst_busy", busy4, 0);
        check("rst_ready", rdy4, 1);
        check("rst_done", done4, 0);
        check("rst_parity", par4, 0);
        tick;
        tick;
        rst = 1'b0;

        csel = 4;
        accept(4'b0000);
        check_frame(4, 4'b0000, -1);
        tick;
        check("done_once", done_m, 0);

        accept(4'b1011);
        check_frame(4, 4'b1011, -1);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        csel = 2;
        din       = 4'h3;
        din_valid = 1'b1;
        tick;
        din = 4'hE;
        check_frame(2, 4'h3, -1);
        tick;
        din_valid = 1'b0;
        check_frame(2, 4'hE, -1);
        tick;
        check("b2b_idle", busy_m, 0);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        csel = 4;
        accept(4'h1);
        check_frame(4, 4'h1, 8);
        tick;
        check("ignored_busy", busy_m, 0);
        check("ignored_tx", tx_m, 1);
        check("ignored_par", par_m, 0);

        accept(4'h1);
        repeat (21) tick;
        check("pre_rst_parity_tx", tx_m, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", tx_m, 1);
        check("midrst_busy", busy_m, 0);
        check("midrst_done", done_m, 0);
        check("midrst_parity", par_m, 0);
        tick;
        rst = 1'b0;
        repeat (10) begin
            check("post_rst_done", done_m, 0);
            check("post_rst_ready", rdy_m, 1);
            tick;
        end

        csel = 1;
        for (int d = 0; d < 16; d++) begin
            accept(4'(d));
            check_frame(1, 4'(d), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial framing controller that sequences the 4-bit odd-parity generator into a transmit link. It accepts one nibble per valid/ready handshake and computes its odd parity bit. It then shifts out a 7-bit frame on a single line: start, 4 data bits LSB first, parity, stop. It sits between a nibble producer and a serial wire, and provides the bit-timing and handshake that the combinational parity generator lacks.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
CNT_W, 8, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
din  input  4  nibble to send; din[0] is transmitted first.
din_valid  input  1  producer has a nibble on din.
din_ready  output  1  block can accept a nibble this cycle.
tx  output  1  serial line; idle level 1. Registered.
busy  output  1  high while a frame is in progress (any state except IDLE).
parity_out  output  1  odd parity bit of the most recently accepted nibble. Registered.
frame_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst.
- While rst is high, and immediately on its assertion: state=IDLE, tx=1, busy=0, parity_out=0, frame_done=0, bit counter=0, timing counter=0, shift register=0. din_ready=1, because it is decoded from state==IDLE.
- Odd parity rule: p = ~(din[3]^din[2]^din[1]^din[0]). The count of ones across the 4 data bits plus p is always odd.
- Accept: a handshake occurs at a rising edge where din_valid=1 and din_ready=1. At that edge the block loads din into the shift register, loads p into parity_out, and moves to START.
- din and din_valid are ignored in every state other than IDLE. Nothing is queued.
- States, each held for exactly CLKS_PER_BIT cycles. The timing counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change.
  - IDLE: tx=1. Move to START on accept.
  - START: tx=0. Then move to DATA with bit index 0.
  - DATA: tx=shift[0]. At the end of each bit period, shift right and increment the bit index. After bit index 3 completes, move to PARITY.
  - PARITY: tx=parity_out. Then move to STOP.
  - STOP: tx=1. At the end of the period, move to IDLE and assert frame_done for one cycle.
- Cycle timing:
  - tx is registered. If the accept happens at edge k, tx=0 in the cycles after edges k .. k+C-1, where C=CLKS_PER_BIT.
  - Frame length is 7*C cycles.
  - IDLE is re-entered at edge k+7C. frame_done=1 and din_ready=1 during the cycle that follows.
  - The earliest next accept is edge k+7C+1, so back-to-back frames have a period of 7C+1 cycles with exactly one idle cycle of tx=1.
- CLKS_PER_BIT=1: each state lasts exactly one cycle; no special casing.
- Reset asserted mid-frame: the frame is abandoned. tx returns to 1 asynchronously, no frame_done is produced, and din_ready=1 after release.
- parity_out holds its value until the next accept.

Decomposition:
- Shared package/include holds:
  - state encodings: S_IDLE=0, S_START=1, S_DATA=2, S_PARITY=3, S_STOP=4, 3-bit;
  - FRAME_BITS=7, START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
- Natural sub-module: odd_parity4, combinational. Inputs a,b,c,d; output p. It is instantiated on din and used at accept.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle → tx=1, busy=0, din_ready=1, frame_done=0, parity_out=0 immediately, before any clock edge.
- Zero nibble, C=4: din=4'b0000 accepted → tx is 0 for 4 cycles (start), then 0,0,0,0 each for 4 cycles, parity 1 for 4 cycles, stop 1 for 4 cycles. parity_out=1. frame_done pulses once, 28 cycles after accept.
- Mixed nibble, C=4: din=4'b1011 → data bits on tx in order 1,1,0,1, then parity 0. parity_out=0. busy high for exactly 28 cycles.
- Back-to-back: din_valid held high with 4'h3 then 4'hE, C=2 → two frames with period 15 cycles, one idle cycle between them, parities 1 then 0, two frame_done pulses.
- Ignored request: pulse din_valid with din=4'hF during DATA of a 4'h1 frame → the frame still carries 4'h1 with parity 0, and no second frame starts.
- Mid-frame reset plus exhaustive sweep:
  - Assert rst during PARITY → tx=1 at once, no frame_done.
  - Then sweep din=0..15 with C=1 → the parity observed on tx matches the odd-parity rule for all 16 values.
